// File: rtl/mac_pkg.sv
// Shared types and helpers for the saturating MAC accumulator.
package mac_pkg;

  typedef enum logic {StAccum, StHold} state_e;

  // Largest positive value of a two's-complement number of the given width.
  function automatic longint sat_max(input int unsigned acc_w);
    return (longint'(1) <<< (acc_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

  // Counter width able to hold max_terms itself.
  function automatic int unsigned cnt_w(input int unsigned max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/mac_accum_sat_add.sv
// Combinational signed add of an accumulator and a sign-extended term, clamped to A_W bits.
module mac_accum_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned A_W = 24,
  parameter int unsigned B_W = 24
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [A_W-1:0] sum_o,
  output logic           clamp_o
);

  localparam logic signed [A_W:0] Max = (A_W + 1)'(sat_max(A_W));
  localparam logic signed [A_W:0] Min = (A_W + 1)'(sat_min(A_W));

  logic signed [A_W:0] a_ext;
  logic signed [A_W:0] b_ext;
  logic signed [A_W:0] wide;

  // One guard bit is enough: the true sum of two A_W-bit values never overflows A_W+1 bits.
  assign a_ext = {a_i[A_W-1], a_i};
  assign b_ext = {{(A_W + 1 - B_W){b_i[B_W-1]}}, b_i};
  assign wide  = a_ext + b_ext;

  always_comb begin
    sum_o   = wide[A_W-1:0];
    clamp_o = 1'b0;
    if (wide > Max) begin
      sum_o   = Max[A_W-1:0];
      clamp_o = 1'b1;
    end else if (wide < Min) begin
      sum_o   = Min[A_W-1:0];
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accum.sv
// Saturating group accumulator for a signed product stream with a held valid/ready result port.
module mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W    = 15,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned MAX_TERMS = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PROD_W-1:0]             in_prod,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_sum,
  output logic [cnt_w(MAX_TERMS)-1:0]   out_count,
  output logic                          out_sat
);

  localparam int unsigned CntW = cnt_w(MAX_TERMS);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [CntW-1:0]   out_count_q, out_count_d;
  logic              out_sat_q, out_sat_d;

  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum;
  logic              clamp;
  logic [CntW-1:0]   cnt_inc;
  logic              accept;

  assign prod_ext = {{(ACC_W - PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign cnt_inc  = cnt_q + 1'b1;
  assign in_ready = (state_q == StAccum) && !rst;
  assign accept   = in_valid && in_ready;

  mac_accum_sat_add #(
    .A_W(ACC_W),
    .B_W(ACC_W)
  ) u_sat_add (
    .a_i    (acc_q),
    .b_i    (prod_ext),
    .sum_o  (sum),
    .clamp_o(clamp)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      StAccum: begin
        if (accept) begin
          if (in_last || (cnt_inc == CntW'(MAX_TERMS))) begin
            out_sum_d   = sum;
            out_count_d = cnt_inc;
            out_sat_d   = sat_q | clamp;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            state_d     = StHold;
          end else begin
            acc_d = sum;
            cnt_d = cnt_inc;
            sat_d = sat_q | clamp;
          end
        end
      end
      StHold: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule
